pc_trace_monitor: RTL

// Synthesisable, parametrised successor to the datapath debug bench: sits beside DataPath and

---
 rtl/pc_trace_monitor_if.sv | 27 ++
 rtl/pc_trace_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_trace_monitor_if.sv
// Read port of the PC trace monitor: the monitor presents the head trace
// record with rd_valid, the host pops it by holding rd_ready.
interface pc_trace_monitor_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
);
  logic                   rd_valid;
  logic                   rd_ready;
  logic [ADDR_WIDTH-1:0]  rd_pc;
  logic [INSTR_WIDTH-1:0] rd_instr;
  logic                   rd_we;
  logic                   rd_seq_break;
  logic [CNT_WIDTH-1:0]   rd_cycle;

  // Monitor side: drives the head record, receives the host's ready.
  modport master (
    output rd_valid, rd_pc, rd_instr, rd_we, rd_seq_break, rd_cycle,
    input  rd_ready
  );

  // Host side: consumes records.
  modport slave (
    input  rd_valid, rd_pc, rd_instr, rd_we, rd_seq_break, rd_cycle,
    output rd_ready
  );
endinterface

// File: rtl/pc_trace_monitor.sv
// PC trace monitor: samples the datapath PC/instruction stream after a start
// pulse (optionally waiting for a trigger PC), logs up to MAX_CYCLES records
// into a circular buffer and lets a host drain it over a valid/ready port.
module pc_trace_monitor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 20,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   trig_enable,
  input  logic [ADDR_WIDTH-1:0]  trig_pc,
  input  logic [ADDR_WIDTH-1:0]  pc_q,
  input  logic [ADDR_WIDTH-1:0]  pc_d,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   reg_write_enable,
  pc_trace_monitor_if.master     rd,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic                   halt,
  output logic                   overflow,
  output logic [1:0]             state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]       DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]       ONE_C     = (PTR_W+1)'(1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   we;
    logic                   seq_break;
    logic [CNT_WIDTH-1:0]   cycle;
  } rec_t;

  rec_t                  mem [DEPTH];
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  capture, pop, full, last;
  logic [ADDR_WIDTH-1:0] prev_pd_q;
  logic                  prev_valid_q;
  rec_t                  new_rec, rd_rec_q, rd_rec_d;

  assign full = (count_q == DEPTH_C);
  assign pop  = (count_q != '0) && rd.rd_ready;
  assign last = (cycle_count == LAST_CNT);

  // Record assembled from the current datapath sample.
  always_comb begin
    new_rec           = '0;
    new_rec.pc        = pc_q;
    new_rec.instr     = instruction;
    new_rec.we        = reg_write_enable;
    new_rec.seq_break = prev_valid_q && (pc_q != prev_pd_q);
    new_rec.cycle     = cycle_count;
  end

  // Next-state and capture decision; start overrides every state.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (start) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (!trig_enable || (pc_q == trig_pc)) begin
            capture = 1'b1;
            state_d = last ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          capture = 1'b1;
          if (last) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Buffer pointer/occupancy bookkeeping and head-record lookahead.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_rec_d   = rd_rec_q;
    if (start) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) head_d = head_q + 1'b1;
      if (capture) begin
        tail_d = tail_q + 1'b1;
        if (full && !pop) begin
          // Oldest unread record is dropped to make room.
          head_d     = head_q + 1'b1;
          overflow_d = 1'b1;
        end
      end
      if (capture && !pop && !full) count_d = count_q + 1'b1;
      else if (pop && !capture)     count_d = count_q - 1'b1;
      // The head shown next cycle is the record being written now only when
      // it is the sole entry; otherwise it is already in the buffer.
      if (count_d != '0) begin
        if (capture && (count_d == ONE_C)) rd_rec_d = new_rec;
        else                               rd_rec_d = mem[head_d];
      end
    end
  end

  // Control and status registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      cycle_count  <= '0;
      prev_pd_q    <= '0;
      prev_valid_q <= 1'b0;
      rd_rec_q     <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_rec_q   <= rd_rec_d;
      if (start) begin
        cycle_count  <= '0;
        prev_valid_q <= 1'b0;
      end else if (capture) begin
        cycle_count  <= cycle_count + 1'b1;
        prev_pd_q    <= pc_d;
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Trace storage write port.
  // NOTE: the buffer array has no reset; occupancy is reset, so stale entries are never presented.
  always_ff @(posedge clock) begin
    if (capture) mem[tail_q] <= new_rec;
  end

  assign rd.rd_valid     = (count_q != '0);
  assign rd.rd_pc        = rd_rec_q.pc;
  assign rd.rd_instr     = rd_rec_q.instr;
  assign rd.rd_we        = rd_rec_q.we;
  assign rd.rd_seq_break = rd_rec_q.seq_break;
  assign rd.rd_cycle     = rd_rec_q.cycle;
  assign halt            = (state_q == DONE);
  assign overflow        = overflow_q;
  assign state           = state_q;

endmodule
